// File: rtl/rom_p2_arbiter.sv
// ROM port-2 arbiter: shares one 32-bit read port between the memory-stage load path (req0)
// and the debug readback path (req1), with starvation protection and fixed-latency responses.
module rom_p2_arbiter #(
    parameter int unsigned ROM_SIZE     = 4096,
    parameter int unsigned RD_LATENCY   = 1,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req0_valid,
    input  logic [31:0] i_req0_addr,
    output logic        o_req0_ready,
    output logic        o_rsp0_valid,
    output logic [31:0] o_rsp0_data,
    output logic        o_rsp0_err,
    input  logic        i_req1_valid,
    input  logic [31:0] i_req1_addr,
    output logic        o_req1_ready,
    output logic        o_rsp1_valid,
    output logic [31:0] o_rsp1_data,
    output logic        o_rsp1_err,
    output logic        o_mem_stall,
    output logic        o_rom_p2_clk,
    output logic        o_rom_p2_en,
    output logic [31:0] o_rom_p2_addr,
    input  logic [31:0] i_rom_p2_rd
);

    localparam int unsigned Last      = RD_LATENCY - 1;
    localparam logic [7:0]  StarveMax = 8'(STARVE_LIMIT);

    logic [7:0]            starve_cnt_q;
    logic [31:0]           addr_q;
    logic [RD_LATENCY-1:0] pv_q, pid_q, perr_q;

    logic        force1, grant0, grant1;
    logic        acc_valid, acc_err, rom_en, rsp_fire;
    logic [31:0] acc_addr, rsp_data;

    always_comb begin
        force1    = i_req1_valid && (starve_cnt_q == StarveMax);
        grant0    = !i_rst && i_req0_valid && !force1;
        grant1    = !i_rst && i_req1_valid && (!i_req0_valid || force1);
        acc_valid = grant0 || grant1;
        acc_addr  = grant1 ? i_req1_addr : i_req0_addr;
        acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr >= ROM_SIZE);
        rom_en    = acc_valid && !acc_err;
    end

    assign o_req0_ready = grant0;
    assign o_req1_ready = grant1;
    assign o_mem_stall  = !i_rst && i_req0_valid && !grant0;
    assign o_rom_p2_clk = i_clk;
    assign o_rom_p2_en  = rom_en;

    // Idle cycles keep presenting the last issued address.
    always_comb begin
        o_rom_p2_addr = addr_q;
        if (i_rst) begin
            o_rom_p2_addr = 32'h0;
        end else if (rom_en) begin
            o_rom_p2_addr = {acc_addr[31:2], 2'b00};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            starve_cnt_q <= 8'h0;
            addr_q       <= 32'h0;
        end else begin
            if (!i_req1_valid || grant1) begin
                starve_cnt_q <= 8'h0;
            end else if (starve_cnt_q != StarveMax) begin
                starve_cnt_q <= starve_cnt_q + 8'h1;
            end
            if (rom_en) begin
                addr_q <= {acc_addr[31:2], 2'b00};
            end
        end
    end

    // Clearing the pipeline on reset drops any read still in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pv_q   <= '0;
            pid_q  <= '0;
            perr_q <= '0;
        end else begin
            pv_q[0]   <= acc_valid;
            pid_q[0]  <= grant1;
            perr_q[0] <= acc_err;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                pv_q[i]   <= pv_q[i-1];
                pid_q[i]  <= pid_q[i-1];
                perr_q[i] <= perr_q[i-1];
            end
        end
    end

    always_comb begin
        rsp_fire     = !i_rst && pv_q[Last];
        rsp_data     = (rsp_fire && !perr_q[Last]) ? i_rom_p2_rd : 32'h0;
        o_rsp0_valid = rsp_fire && !pid_q[Last];
        o_rsp1_valid = rsp_fire && pid_q[Last];
        o_rsp0_data  = o_rsp0_valid ? rsp_data : 32'h0;
        o_rsp1_data  = o_rsp1_valid ? rsp_data : 32'h0;
        o_rsp0_err   = o_rsp0_valid && perr_q[Last];
        o_rsp1_err   = o_rsp1_valid && perr_q[Last];
    end

endmodule

// File: doc/rom_p2_arbiter.md
Name: rom_p2_arbiter

Overview:
- Shares the ROM second read port (32-bit word granularity) between two requesters: the memory-stage load path (req0) and the debug/loader readback path (req1).
- Sits between the data-fetch stage ROM port-2 interface and the memory stage and debug unit.
- Grants one request per cycle and routes in-order responses back after a fixed read latency.
- Raises a stall to the hazard unit when a memory-stage request cannot be granted.

Parameters:
- ROM_SIZE, 4096, ROM size in bytes; power of two.
- RD_LATENCY, 1, cycles from o_rom_p2_en to valid i_rom_p2_rd; range 1..4.
- STARVE_LIMIT, 8, consecutive cycles req1 may be denied before it is force-granted; range 1..255.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_req0_valid  in  1  memory-stage read request.
- i_req0_addr  in  32  memory-stage byte address.
- o_req0_ready  out  1  req0 granted this cycle.
- o_rsp0_valid  out  1  response for req0.
- o_rsp0_data  out  32  read data for req0.
- o_rsp0_err  out  1  req0 address misaligned or out of range.
- i_req1_valid  in  1  debug read request.
- i_req1_addr  in  32  debug byte address.
- o_req1_ready  out  1  req1 granted this cycle.
- o_rsp1_valid  out  1  response for req1.
- o_rsp1_data  out  32  read data for req1.
- o_rsp1_err  out  1  req1 error.
- o_mem_stall  out  1  to hazard unit: i_req0_valid and not o_req0_ready.
- o_rom_p2_clk  out  1  tied to i_clk.
- o_rom_p2_en  out  1  ROM port-2 read enable.
- o_rom_p2_addr  out  32  ROM port-2 byte address, word aligned.
- i_rom_p2_rd  in  32  ROM port-2 read data.

Behaviour:
- Reset: all outputs 0 except o_rom_p2_clk; starvation counter 0; latency pipeline cleared; in-flight ROM reads are discarded, and no response is issued for them after reset.
- Grant (combinational in the cycle of request), at most one grant per cycle:
  - Default priority goes to req0.
  - req1 is granted when req0 is idle, or when starve_cnt == STARVE_LIMIT.
  - On a forced req1 grant, req0 is denied and o_mem_stall=1.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) each cycle req1 is valid and not granted.
  - Clears on a req1 grant or when req1 is not valid.
- A request is accepted when valid and ready are both high in the same cycle. A requester holds valid and addr stable until ready.
- Address check on the accepted address:
  - err = (addr[1:0] != 0) or (addr >= ROM_SIZE).
  - On error: o_rom_p2_en=0, but a response slot is still scheduled.
  - Valid address: o_rom_p2_en=1, o_rom_p2_addr = {addr[31:2],2'b00}.
- Response pipeline:
  - A shift register of depth RD_LATENCY carries {valid, id, err} per accepted request.
  - Response appears exactly RD_LATENCY cycles after acceptance, on the rsp port matching id, for one cycle.
  - data = i_rom_p2_rd when err=0; data = 0 when err=1.
  - Responses are in order; back-to-back accepts give back-to-back responses with no bubbles.
- No backpressure on responses: requesters must sample rsp in the valid cycle.
- Simultaneous first requests: req0 wins, req1 is denied, starve_cnt becomes 1.
- Idle cycles: o_rom_p2_en=0, and o_rom_p2_addr holds its last value.

Test Plan:
- Reset, then req0 addr 0x10 with ROM[0x10]=0xDEADBEEF, RD_LATENCY=1 -> ready same cycle, o_rom_p2_en=1, rsp0_valid next cycle with 0xDEADBEEF, err=0.
- req0 and req1 both valid for 3 cycles, addrs 0x0 / 0x4 -> req0 granted each cycle; req1 denied; starve_cnt reaches 3; o_mem_stall=0.
- STARVE_LIMIT=2, req0 and req1 continuously valid -> cycles 1,2 grant req0; cycle 3 grants req1 with o_mem_stall=1; cycle 4 grants req0 again.
- req1 addr 0x6 (misaligned), then addr ROM_SIZE -> o_rom_p2_en=0 both times; rsp1_valid with err=1, data=0 after RD_LATENCY.
- RD_LATENCY=3, req0 accepts at cycles 0,1,2 with addrs 0x0,0x4,0x8 -> rsp0_valid in cycles 3,4,5 with matching data in order.
- i_rst asserted one cycle after an accept, RD_LATENCY=2 -> no rsp_valid after reset; all outputs 0 in the reset cycle.
